instr_fetch: RTL and testbench

- Instruction fetch unit: the reader side of the asynchronous program ROM.
- Drives the ROM ADDR bus from an internal fetch PC and samples the combinational ROM data.
- Buffers fetched words in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Supports jump redirect (with flush) and halt.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/instr_fetch.sv | 70 +++++++
 tb/tb_instr_fetch.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants.
// Widths match the program ROM bus.
package cpu_pkg;

  localparam int ADDR_W    = 16;
  localparam int ROM_WIDTH = 21;

  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [ADDR_W-1:0]    pc;
    logic [ROM_WIDTH-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO.
// Head reads zero when empty; flush beats push.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter type T     = fetch_entry_t,
  parameter int  DEPTH = 2,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  T            din,
  output T            head,
  output logic [PW:0] count,
  output logic        full
);

  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_MAX);
  assign do_pop  = pop && !empty;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset; head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, redirect/halt control
// and the prefetch FIFO feeding decode.
module instr_fetch #(
  parameter int ADDR_W    = cpu_pkg::ADDR_W,
  parameter int ROM_WIDTH = cpu_pkg::ROM_WIDTH,
  parameter int DEPTH     = 2,
  parameter logic [ADDR_W-1:0] RESET_PC =
    ADDR_W'(cpu_pkg::RESET_PC)
) (
  input  logic                       CLK,
  input  logic                       RST,
  output logic [ADDR_W-1:0]          ADDR,
  input  logic [ROM_WIDTH-1:0]       data,
  output logic [ROM_WIDTH-1:0]       instr,
  output logic [ADDR_W-1:0]          instr_pc,
  output logic                       instr_valid,
  input  logic                       instr_ready,
  input  logic                       jmp_en,
  input  logic [ADDR_W-1:0]          jmp_addr,
  input  logic                       halt,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  typedef struct packed {
    logic [ADDR_W-1:0]    pc;
    logic [ROM_WIDTH-1:0] word;
  } entry_t;

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] pc;
  logic              full;
  logic              pop;
  logic              push;
  entry_t            din;
  entry_t            head;

  assign pop  = instr_valid && instr_ready;
  assign push = !jmp_en && !halt && (!full || pop);

  assign din.pc   = pc;
  assign din.word = data;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         pc <= RESET_PC;
    else if (jmp_en) pc <= jmp_addr;
    else if (push)   pc <= pc + PC_ONE;
  end

  fetch_fifo #(
    .T     (entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .flush (jmp_en),
    .din   (din),
    .head  (head),
    .count (fifo_count),
    .full  (full)
  );

  assign ADDR        = pc;
  assign instr       = head.word;
  assign instr_pc    = head.pc;
  assign instr_valid = (fifo_count != '0);

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch.
// ROM model returns {5'b10101, ADDR}.
module tb_instr_fetch;

  localparam int AW = 16;
  localparam int RW = 21;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [AW-1:0] ADDR;
  logic [RW-1:0] data;
  logic [RW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready = 1'b1;
  logic          jmp_en = 1'b0;
  logic [AW-1:0] jmp_addr = '0;
  logic          halt = 1'b0;
  logic [1:0]    fifo_count;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] mon_e;

  always #5 CLK = ~CLK;

  assign data = {5'b10101, ADDR};

  instr_fetch #(
    .ADDR_W    (AW),
    .ROM_WIDTH (RW),
    .DEPTH     (2),
    .RESET_PC  (16'h0000)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ADDR        (ADDR),
    .data        (data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jmp_en      (jmp_en),
    .jmp_addr    (jmp_addr),
    .halt        (halt),
    .fifo_count  (fifo_count)
  );

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must match the next expected PC.
  always @(negedge CLK) begin
    if (instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_out: got pc %h expected none",
                 instr_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_pc", {16'h0, instr_pc}, {16'h0, mon_e});
        chk("out_instr", {11'h0, instr},
            {11'h0, 5'b10101, mon_e});
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(int n);
    repeat (n) tick();
  endtask

  task automatic expect_seq(logic [AW-1:0] start, int n);
    logic [AW-1:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(p);
      p = p + 16'h1;
    end
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d pending expected 0",
               name, exp_q.size());
      exp_q.delete();
    end
    instr_ready = 1'b0;
  endtask

  task automatic restart();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    // Reset state and basic streaming
    tick();
    chk("rst_addr", {16'h0, ADDR}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_count", {30'h0, fifo_count}, 32'h0);
    chk("rst_instr", {11'h0, instr}, 32'h0);
    chk("rst_pc", {16'h0, instr_pc}, 32'h0);
    expect_seq(16'h0000, 6);
    RST = 1'b0;
    tick();
    chk("lat_valid", {31'h0, instr_valid}, 32'h1);
    chk("lat_count", {30'h0, fifo_count}, 32'h1);
    chk("lat_addr", {16'h0, ADDR}, 32'h1);
    drain("stream");

    // Backpressure: FIFO saturates, PC stalls
    restart();
    tick();
    chk("bp1_count", {30'h0, fifo_count}, 32'h1);
    chk("bp1_addr", {16'h0, ADDR}, 32'h1);
    ticks(4);
    chk("bp_count", {30'h0, fifo_count}, 32'h2);
    chk("bp_addr", {16'h0, ADDR}, 32'h2);
    chk("bp_head", {16'h0, instr_pc}, 32'h0);
    expect_seq(16'h0000, 4);
    instr_ready = 1'b1;
    drain("backpressure");

    // Jump with full FIFO and a pop on the jump edge
    restart();
    ticks(3);
    chk("pj_count", {30'h0, fifo_count}, 32'h2);
    expect_seq(16'h0000, 1);
    instr_ready = 1'b1;
    jmp_en = 1'b1;
    jmp_addr = 16'h0040;
    tick();
    jmp_en = 1'b0;
    chk("j_count", {30'h0, fifo_count}, 32'h0);
    chk("j_valid", {31'h0, instr_valid}, 32'h0);
    chk("j_addr", {16'h0, ADDR}, 32'h40);
    expect_seq(16'h0040, 3);
    tick();
    chk("j2_valid", {31'h0, instr_valid}, 32'h1);
    chk("j2_pc", {16'h0, instr_pc}, 32'h40);
    drain("jump");

    // Back-to-back jumps under halt, then wrap-around
    restart();
    halt = 1'b1;
    jmp_en = 1'b1;
    jmp_addr = 16'h1234;
    tick();
    jmp_addr = 16'hFFFE;
    tick();
    jmp_en = 1'b0;
    chk("bb_addr", {16'h0, ADDR}, 32'hFFFE);
    chk("bb_count", {30'h0, fifo_count}, 32'h0);
    tick();
    chk("hj_addr", {16'h0, ADDR}, 32'hFFFE);
    chk("hj_valid", {31'h0, instr_valid}, 32'h0);
    halt = 1'b0;
    expect_seq(16'hFFFE, 5);
    instr_ready = 1'b1;
    drain("wrap");

    // Halt drains the buffer and holds the PC
    expect_seq(16'h0000, 6);
    instr_ready = 1'b1;
    restart();
    ticks(3);
    halt = 1'b1;
    ticks(4);
    chk("h_count", {30'h0, fifo_count}, 32'h0);
    chk("h_valid", {31'h0, instr_valid}, 32'h0);
    chk("h_addr", {16'h0, ADDR}, 32'h3);
    halt = 1'b0;
    drain("halt");

    // Asynchronous reset mid-stream
    expect_seq(16'h0000, 3);
    instr_ready = 1'b1;
    restart();
    drain("pre_reset");
    chk("ar_pre_valid", {31'h0, instr_valid}, 32'h1);
    chk("ar_pre_pc", {16'h0, instr_pc}, 32'h3);
    #3;
    RST = 1'b1;
    #1;
    chk("ar_valid", {31'h0, instr_valid}, 32'h0);
    chk("ar_count", {30'h0, fifo_count}, 32'h0);
    chk("ar_instr", {11'h0, instr}, 32'h0);
    chk("ar_pc", {16'h0, instr_pc}, 32'h0);
    chk("ar_addr", {16'h0, ADDR}, 32'h0);
    #2;
    RST = 1'b0;
    expect_seq(16'h0000, 3);
    instr_ready = 1'b1;
    drain("post_reset");

    ticks(2);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
